// File: rtl/instruction_memory_sync_if.sv
// Fetch/load bus between the pipeline front end and the instruction memory.
// The master is the core side; the slave is the memory.
interface instruction_memory_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  stall;
  logic                  flush;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  fault;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_err;
  logic                  init_done;

  modport master (
    output fetch_req, fetch_addr, stall, flush, load_en, load_addr, load_data,
    input  fetch_ready, instr_valid, instruction, instr_addr, fault, load_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, flush, load_en, load_addr, load_data,
    output fetch_ready, instr_valid, instruction, instr_addr, fault, load_err, init_done
  );
endinterface

// File: rtl/instruction_memory_sync.sv
// Synchronous-read instruction memory with a one-cycle fetch pipeline,
// stall/flush control, a run-time load port and a post-reset NOP fill.
module instruction_memory_sync #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instruction_memory_sync_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state, next_state;
  logic [IDX_W-1:0]      clr_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  fetch_ready, init_done, load_drop, fetch_acc;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  instr_valid, fault, load_err;
  logic [DATA_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0] instr_addr;

  // Word indices and address checks; anything misaligned or past the end is bad.
  logic [WA_W-1:0] fetch_word, load_word;
  logic            fetch_bad, load_bad;
  assign fetch_word = bus.fetch_addr[ADDR_WIDTH-1:2];
  assign load_word  = bus.load_addr[ADDR_WIDTH-1:2];
  assign fetch_bad  = (|bus.fetch_addr[1:0]) || (fetch_word >= WA_W'(DEPTH));
  assign load_bad   = (|bus.load_addr[1:0])  || (load_word  >= WA_W'(DEPTH));

  // State register and clear counter; reset always restarts the fill from index 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) clr_idx <= clr_idx + IDX_W'(1);
    end
  end

  // Leave CLEAR once the last word has been written.
  always_comb begin
    next_state = state;
    if (state == CLEAR && clr_idx == IDX_W'(DEPTH - 1)) next_state = RUN;
  end

  // Per-state outputs: fill writes during CLEAR, load writes and fetch handshake in RUN.
  always_comb begin
    fetch_ready = 1'b0;
    init_done   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_idx;
    mem_wdata   = NOP_WORD;
    load_drop   = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        load_drop = bus.load_en;
      end
      RUN: begin
        init_done   = 1'b1;
        fetch_ready = !bus.load_en && !bus.stall && !bus.flush;
        mem_we      = bus.load_en && !load_bad;
        mem_waddr   = load_word[IDX_W-1:0];
        mem_wdata   = bus.load_data;
        load_drop   = bus.load_en && load_bad;
      end
      default: ;
    endcase
  end

  // Storage array; no reset, the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign fetch_acc = bus.fetch_req && fetch_ready;

  // Output stage: flush beats stall beats an accepted fetch; idle drops valid only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
      instr_addr  <= '0;
      fault       <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= load_drop;
      if (bus.flush) begin
        instr_valid <= 1'b0;
        instruction <= NOP_WORD;
        fault       <= 1'b0;
      end else if (bus.stall) begin
        instr_valid <= instr_valid;
      end else if (fetch_acc) begin
        instr_valid <= 1'b1;
        instr_addr  <= bus.fetch_addr;
        fault       <= fetch_bad;
        instruction <= fetch_bad ? NOP_WORD : mem[fetch_word[IDX_W-1:0]];
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.init_done   = init_done;
  assign bus.instr_valid = instr_valid;
  assign bus.instruction = instruction;
  assign bus.instr_addr  = instr_addr;
  assign bus.fault       = fault;
  assign bus.load_err    = load_err;
endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync (DEPTH=128, NOP=0).
module tb_instruction_memory_sync;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 128;
  localparam logic [DW-1:0] WA = 32'hA000_0001;
  localparam logic [DW-1:0] WB = 32'hB000_0002;
  localparam logic [DW-1:0] WC = 32'hC000_0003;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instruction_memory_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instruction_memory_sync #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, bus.fetch_ready, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_instr"}, bus.instruction, 0);
    chk({tag, "_iaddr"}, bus.instr_addr, 0);
    chk({tag, "_fault"}, bus.fault, 0);
    chk({tag, "_lderr"}, bus.load_err, 0);
    chk({tag, "_init"},  bus.init_done, 0);
  endtask

  // Reset has just been released between edges; expect exactly DEPTH busy edges.
  task automatic run_clear(input string tag, input bit clear_load);
    int viol;
    viol = 0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h7C;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      if (bus.fetch_ready !== 1'b0 || bus.init_done !== 1'b0 || bus.instr_valid !== 1'b0) viol++;
      if (clear_load) begin
        if (k == 10) begin
          bus.load_en = 1'b1; bus.load_addr = 32'h4; bus.load_data = 32'hDEAD_BEEF;
        end
        if (k == 11) begin
          bus.load_en = 1'b0;
          chk({tag, "_clrload_err"}, bus.load_err, 1);
        end
        if (k == 12) chk({tag, "_clrload_err_end"}, bus.load_err, 0);
      end
    end
    chk({tag, "_busy_cycles"}, viol, 0);
    tick();
    chk({tag, "_ready_up"}, bus.fetch_ready, 1);
    chk({tag, "_init_up"},  bus.init_done, 1);
    bus.fetch_req = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.stall = 0; bus.flush = 0;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    #1 chk_reset("rst0");
    tick(); tick();
    reset_n = 1'b1;
    run_clear("clr0", 1'b1);

    // After the fill, word 1 is NOP even though a CLEAR-time load targeted it.
    fetch(32'h4);
    chk("nop_valid", bus.instr_valid, 1);
    chk("nop_data",  bus.instruction, 0);
    chk("nop_addr",  bus.instr_addr, 32'h4);
    chk("nop_fault", bus.fault, 0);

    // Load then fetch next cycle.
    bus.fetch_req = 0;
    bus.load_en = 1; bus.load_addr = 32'h20; bus.load_data = 32'h2002_0005;
    #1 chk("load_blocks_ready", bus.fetch_ready, 0);
    tick();
    chk("load_ok_no_err", bus.load_err, 0);
    chk("idle_drops_valid", bus.instr_valid, 0);
    bus.load_en = 0;
    fetch(32'h20);
    chk("raw_data",  bus.instruction, 32'h2002_0005);
    chk("raw_addr",  bus.instr_addr, 32'h20);
    chk("raw_fault", bus.fault, 0);
    chk("raw_valid", bus.instr_valid, 1);
    bus.fetch_req = 0;

    // Back-to-back fetches.
    do_load(32'h0, WA); do_load(32'h4, WB); do_load(32'h8, WC);
    fetch(32'h0); chk("b2b_a", bus.instruction, WA); chk("b2b_a_v", bus.instr_valid, 1);
    fetch(32'h4); chk("b2b_b", bus.instruction, WB); chk("b2b_b_v", bus.instr_valid, 1);
    fetch(32'h8); chk("b2b_c", bus.instruction, WC); chk("b2b_c_v", bus.instr_valid, 1);
    fetch(32'h202);
    chk("mis_fault", bus.fault, 1); chk("mis_instr", bus.instruction, 0);
    chk("mis_valid", bus.instr_valid, 1); chk("mis_addr", bus.instr_addr, 32'h202);
    fetch(32'h200);
    chk("oor_fault", bus.fault, 1); chk("oor_instr", bus.instruction, 0);
    fetch(32'h1FC);
    chk("last_fault", bus.fault, 0); chk("last_valid", bus.instr_valid, 1);

    // Stall holds B for 3 cycles, then flush+stall clears.
    fetch(32'h4); chk("pre_stall_b", bus.instruction, WB);
    bus.fetch_addr = 32'h8; bus.stall = 1;
    #1 chk("stall_ready", bus.fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_data",  bus.instruction, WB);
      chk("stall_hold_valid", bus.instr_valid, 1);
      chk("stall_hold_addr",  bus.instr_addr, 32'h4);
    end
    bus.flush = 1;
    tick();
    chk("flush_valid", bus.instr_valid, 0);
    chk("flush_instr", bus.instruction, 0);
    chk("flush_fault", bus.fault, 0);
    bus.stall = 0; bus.flush = 0; bus.fetch_req = 0;

    // Rejected loads.
    do_load(32'h13, 32'hFFFF_FFFF);
    chk("misload_err", bus.load_err, 1);
    tick();
    chk("misload_err_end", bus.load_err, 0);
    fetch(32'h10); chk("misload_mem", bus.instruction, 0);
    bus.fetch_req = 0;
    do_load(32'h200, 32'h1234_5678);
    chk("oorload_err", bus.load_err, 1);
    fetch(32'h0); chk("oorload_mem", bus.instruction, WA);

    // Reset during RUN with live outputs.
    fetch(32'h8); chk("pre_rst_c", bus.instruction, WC);
    reset_n = 1'b0;
    #1 chk_reset("rst_run");
    tick();
    reset_n = 1'b1;
    run_clear("clr1", 1'b0);
    fetch(32'h0); chk("cleared_a", bus.instruction, 0);
    bus.fetch_req = 0;

    // Reset mid-CLEAR at clr_idx=50.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (50) tick();
    chk("mid_clear_init", bus.init_done, 0);
    reset_n = 1'b0;
    #1 chk_reset("rst_clear");
    tick();
    reset_n = 1'b1;
    run_clear("clr2", 1'b0);
    fetch(32'h20); chk("cleared_raw", bus.instruction, 0);
    bus.fetch_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
